// File: rtl/sync_fifo_std_pkg.sv
// rtl/sync_fifo_std_pkg.sv - shared FIFO pointer sizing and full/empty decode
// Kept width-agnostic (32-bit zero-extended pointers) so async FIFOs can reuse it.
package sync_fifo_std_pkg;

   typedef logic [31:0] ptr_word_t;

   typedef struct packed {
      logic empty;
      logic full;
   } fifo_flags_t;

   // One extra wrap bit distinguishes full from empty when the addresses match.
   function automatic int ptr_width(input int addr_width);
      return addr_width + 1;
   endfunction

   function automatic fifo_flags_t decode_flags(input ptr_word_t wr_ptr,
                                                input ptr_word_t rd_ptr,
                                                input int unsigned addr_width);
      ptr_word_t   diff;
      fifo_flags_t flags;
      diff        = wr_ptr ^ rd_ptr;
      flags.empty = (diff == '0);
      flags.full  = ((diff & ((32'd1 << addr_width) - 32'd1)) == '0) && diff[addr_width];
      return flags;
   endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// rtl/fifo_sdp_ram.sv - simple dual-port RAM, one write port, registered read port
// Array is unreset so it maps onto block RAM; only the output register clears.
module fifo_sdp_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_std.sv
// rtl/sync_fifo_std.sv - standard-mode synchronous FIFO, 1-cycle registered read
// Optional overflow/underflow pulses are built only when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_std
   import sync_fifo_std_pkg::*;
#(
   parameter int DATA_WIDTH         = 8,
   parameter int ADDR_WIDTH         = 4,
   parameter int ALMOST_FULL_THRESH = 2**ADDR_WIDTH - 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   data_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int PW = ptr_width(ADDR_WIDTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          wr_accept;
   logic          rd_accept;
   fifo_flags_t   flags;

   assign flags       = decode_flags(ptr_word_t'(wr_ptr_q), ptr_word_t'(rd_ptr_q), ADDR_WIDTH);
   assign empty       = flags.empty;
   assign full        = flags.full;
   assign data_count  = wr_ptr_q - rd_ptr_q;
   assign almost_full = int'(data_count) >= ALMOST_FULL_THRESH;

   // Requests on a reset edge are ignored, so neither RAM nor pointers move.
   assign wr_accept = wr_en && !full && !rst;
   assign rd_accept = rd_en && !empty && !rst;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_accept) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_accept) rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   fifo_sdp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_accept),
      .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wdata_i (din),
      .re_i    (rd_accept),
      .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata_o (dout)
   );

`ifdef SYNC_FIFO_ERR_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= wr_en && full;
         underflow_q <= rd_en && empty;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: doc/sync_fifo_std.md
Name: sync_fifo_std

Overview:
- Single-clock, standard-mode (non-FWFT) FIFO with a block-RAM style registered read port and 1-cycle read latency.
- Sits directly upstream of the team's FWFT adapter and drives its fifo_empty / fifo_rd_en / fifo_dout interface.
- Also usable standalone wherever a plain synchronous FIFO is needed.

Parameters:
- DATA_WIDTH, 8: word width in bits; must be >= 1.
- ADDR_WIDTH, 4: log2 of depth; DEPTH = 2**ADDR_WIDTH; must be >= 1.
- ALMOST_FULL_THRESH, 2**ADDR_WIDTH-1: almost_full asserts when data_count >= this value; legal range 1..DEPTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- wr_en  input  1  write request.
- din  input  DATA_WIDTH  write data.
- full  output  1  no free entries.
- almost_full  output  1  data_count >= ALMOST_FULL_THRESH.
- rd_en  input  1  read request.
- dout  output  DATA_WIDTH  read data; valid the cycle after an accepted read.
- empty  output  1  no stored entries.
- data_count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
- overflow  output  1  error pulse; see Optional Feature.
- underflow  output  1  error pulse; see Optional Feature.

Behaviour:
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide; the low ADDR_WIDTH bits address the RAM, the MSB is the wrap bit.
  - Both increment modulo 2**(ADDR_WIDTH+1).
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - data_count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
  - All flags are decoded combinationally from the registered pointers; there is no lookahead.
- Accepted write: wr_en && !full at the edge. RAM[wr_ptr] <= din and wr_ptr increments. A write while full is dropped; RAM and pointer are unchanged.
- Accepted read: rd_en && !empty at the edge. dout <= RAM[rd_ptr] and rd_ptr increments. dout is observable from the following cycle. A read while empty is dropped; dout and rd_ptr are unchanged.
- dout holds its last value until the next accepted read.
- Simultaneous read and write:
  - At 0 < count < DEPTH: both are accepted and data_count is unchanged.
  - When empty: only the write is accepted; empty deasserts the next cycle; the word is readable no earlier than the following edge.
  - When full: only the read is accepted; full deasserts the next cycle.
- No read-during-write address collision is possible, because reads require !empty and writes require !full.
- Write-to-empty-deassert latency is 1 cycle. Read-to-full-deassert latency is 1 cycle.
- Reset (also when asserted mid-operation):
  - Pointers cleared to 0; dout = 0; overflow = 0; underflow = 0.
  - After the reset edge: empty = 1, full = 0, almost_full = 0, data_count = 0.
  - RAM contents are not reset and are discarded logically.
  - wr_en and rd_en are ignored on any edge where rst = 1.
- ALMOST_FULL_THRESH = DEPTH makes almost_full identical to full.

Optional Feature:
- Macro: SYNC_FIFO_ERR_EN.
- Defined:
  - overflow is a registered 1-cycle pulse the cycle after an edge with wr_en && full && !rst.
  - underflow is the same for rd_en && empty && !rst.
  - Both clear on reset.
- Undefined: overflow and underflow are tied to 0 and no error logic is synthesized.

Decomposition:
- Shared fifo package/header holds:
  - the pointer-width derivation (ADDR_WIDTH+1);
  - the full/empty decode as a reusable function shared with future async FIFOs.
- One sub-module, fifo_sdp_ram: simple dual-port RAM with one write port, one registered read port, and a read-enable; inferable as block RAM.
- The top level holds pointers, flags, and the error logic.

Test Plan:
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=2 and ALMOST_FULL_THRESH=3 unless stated otherwise.
- Fill: reset, then write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> almost_full rises after the 3rd write; full = 1 and data_count = 4 after the 4th; empty stays 1 until the edge after the 1st write.
- Overflow and drain: write 0x55 while full -> data_count stays 4 and overflow pulses once (with macro). Then read 4 times -> dout = 0x11, 0x22, 0x33, 0x44, each 1 cycle after its rd_en; empty = 1 after the last read.
- Underflow: rd_en while empty -> dout holds 0x44, pointers unchanged, underflow pulses once (with macro; stays 0 without).
- Wrap-around and concurrency: hold count at 2 and assert rd_en and wr_en together for 20 cycles with an incrementing pattern -> data_count constant at 2, data read in exact write order across pointer wraps.
- Reset mid-operation: at count 3, assert rst for 1 cycle -> empty = 1, data_count = 0, dout = 0, full = 0. Then write 0xA5 and read -> dout = 0xA5.
- Integration: chain with the FWFT adapter under random wr_en/rd_en (50% each) for 1000 words -> scoreboard shows no loss, duplication, or reordering.
